// File: rtl/gain_norm_pkg.sv
// Shared defaults and FSM state encoding for the gain_norm block normalizer.
package gain_norm_pkg;

  localparam int W_DEF          = 32;
  localparam int N_DEF          = 16;
  localparam int MAX_SHIFT_DEF  = 10;
  localparam int TARGET_MSB_DEF = 29;
  localparam int SHIFT_W        = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/gain_norm_shift_sel.sv
// Combinational shift selection: largest s in 0..MAX_SHIFT keeping (peak << s) below 2^TARGET_MSB.
module gain_norm_shift_sel
  import gain_norm_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int MAX_SHIFT  = MAX_SHIFT_DEF,
  parameter int TARGET_MSB = TARGET_MSB_DEF
) (
  input  logic [W-1:0]       peak,
  output logic [SHIFT_W-1:0] shift
);

  // Widened so that every candidate shift is evaluated without losing bits.
  localparam int           PW    = W + MAX_SHIFT;
  localparam logic [PW-1:0] LIMIT = PW'(1) << TARGET_MSB;

  logic [PW-1:0] wide_peak;

  assign wide_peak = PW'(peak);

  // NOTE: shift gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    shift = '0;
    for (int s = 0; s <= MAX_SHIFT; s++) begin
      if ((wide_peak << s) < LIMIT) shift = SHIFT_W'(s);
    end
  end

endmodule

// File: rtl/gain_norm.sv
// Block gain normalizer: buffers N samples, finds their peak magnitude, then
// replays the block left-shifted by the largest safe amount.
module gain_norm
  import gain_norm_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int N          = N_DEF,
  parameter int MAX_SHIFT  = MAX_SHIFT_DEF,
  parameter int TARGET_MSB = TARGET_MSB_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_shift,
  output logic         out_last
);

  localparam int              IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);
  localparam logic [W-1:0]    MAG_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    MOST_NEG = {1'b1, {(W-1){1'b0}}};

  state_t              state, state_next;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       rd_addr;
  logic [W-1:0]        peak;
  logic [W-1:0]        mag;
  logic [W-1:0]        rd_data;
  logic [W-1:0]        shifted;
  logic [SHIFT_W-1:0]  shift;
  logic [SHIFT_W-1:0]  shift_calc;
  logic                in_xfer;
  logic                out_xfer;
  logic                at_last;

  logic [W-1:0] buffer [N];

  assign at_last  = (idx == LAST_IDX);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // -2^(W-1) has no positive counterpart, so its magnitude saturates.
  always_comb begin
    mag = in_data;
    if (in_data[W-1]) mag = (in_data == MOST_NEG) ? MAG_MAX : -in_data;
  end

  gain_norm_shift_sel #(
    .W          (W),
    .MAX_SHIFT  (MAX_SHIFT),
    .TARGET_MSB (TARGET_MSB)
  ) u_shift_sel (
    .peak  (peak),
    .shift (shift_calc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = !rst;
        if (in_valid && at_last) state_next = CALC;
      end
      CALC: begin
        state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = !rst;
        if (out_ready && at_last) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      peak  <= '0;
      shift <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            idx <= at_last ? '0 : idx + IW'(1);
            if (mag > peak) peak <= mag;
          end
        end
        CALC: begin
          shift <= shift_calc;
        end
        DRAIN: begin
          if (out_xfer) begin
            if (at_last) begin
              idx  <= '0;
              peak <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read one entry ahead on a transfer so the next sample is ready the following cycle.
  always_comb begin
    rd_addr = idx;
    if (out_xfer) rd_addr = at_last ? '0 : idx + IW'(1);
  end

  // NOTE: the sample buffer is deliberately not reset; its contents are always written before being read.
  always_ff @(posedge clk) begin
    if (in_xfer) buffer[idx] <= in_data;
    rd_data <= buffer[rd_addr];
  end

  // The chosen shift keeps every |sample| << shift below 2^TARGET_MSB, so a
  // plain left shift cannot reach the sign bit and preserves the sign.
  assign shifted   = rd_data << shift;
  assign out_data  = out_valid ? shifted : '0;
  assign out_shift = out_valid ? shift : '0;
  assign out_last  = out_valid && at_last;

endmodule

// File: tb/tb_gain_norm.sv
// Directed, table-driven bench for gain_norm with hand-computed expected blocks.
module tb_gain_norm;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_shift;
  logic        out_last;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [N-1:0][31:0] smp;
    logic [N-1:0][31:0] expd;
    logic [3:0]         shift;
  } vec_t;

  vec_t vecs [7];

  gain_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_shift (out_shift),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send(input logic [31:0] d);
    int guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) timeout("send in_ready");
    @(negedge clk);
  endtask

  task automatic drain(input int v, input bit stall);
    int  k = 0;
    int  guard = 0;
    bit  rdy = !stall;
    while (k < N && guard < 200) begin
      out_ready = rdy;
      check($sformatf("v%0d valid[%0d]", v, k), 32'(out_valid), 32'd1);
      check($sformatf("v%0d data[%0d]", v, k), out_data, vecs[v].expd[k]);
      check($sformatf("v%0d shift[%0d]", v, k), 32'(out_shift), 32'(vecs[v].shift));
      check($sformatf("v%0d last[%0d]", v, k), 32'(out_last), (k == N - 1) ? 32'd1 : 32'd0);
      check($sformatf("v%0d in_ready_drain[%0d]", v, k), 32'(in_ready), 32'd0);
      if (rdy) k++;
      @(negedge clk);
      guard++;
      if (stall) rdy = !rdy;
    end
    out_ready = 1'b0;
    if (k < N) timeout($sformatf("v%0d drain", v));
    check($sformatf("v%0d valid_after", v), 32'(out_valid), 32'd0);
    check($sformatf("v%0d in_ready_after", v), 32'(in_ready), 32'd1);
  endtask

  task automatic run_block(input int v, input bit stall, input bit hold, input logic [31:0] nxt);
    for (int i = 0; i < N; i++) send(vecs[v].smp[i]);
    if (hold) in_data = nxt;
    else      in_valid = 1'b0;
    check($sformatf("v%0d calc_valid", v), 32'(out_valid), 32'd0);
    check($sformatf("v%0d calc_in_ready", v), 32'(in_ready), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d latency", v), 32'(out_valid), 32'd1);
    drain(v, stall);
  endtask

  initial begin
    // Alternating +/-2^19: 2^19 << 10 reaches 2^29, so shift 9 and +/-2^28.
    for (int i = 0; i < N; i++) begin
      vecs[0].smp[i]  = (i % 2 != 0) ? 32'hFFF8_0000 : 32'h0008_0000;
      vecs[0].expd[i] = (i % 2 != 0) ? 32'hF000_0000 : 32'h1000_0000;
    end
    vecs[0].shift = 4'd9;
    // All zeros: maximum shift.
    vecs[1].smp   = '0;
    vecs[1].expd  = '0;
    vecs[1].shift = 4'd10;
    // Contains -2^31: saturated peak forces shift 0, data unchanged.
    for (int i = 0; i < N; i++) vecs[2].smp[i] = 32'(i * 1000 - 7000);
    vecs[2].smp[5] = 32'h8000_0000;
    vecs[2].expd   = vecs[2].smp;
    vecs[2].shift  = 4'd0;
    // Peak 1000: shift 10, data * 1024.
    for (int i = 0; i < N; i++) begin
      vecs[3].smp[i]  = 32'(i * 100 - 500);
      vecs[3].expd[i] = 32'(i * 102400 - 512000);
    end
    vecs[3].shift = 4'd10;
    // Peak 2^19-1: largest peak still allowed shift 10.
    for (int i = 0; i < N; i++) begin
      vecs[4].smp[i]  = 32'(-i);
      vecs[4].expd[i] = 32'(-i * 1024);
    end
    vecs[4].smp[3]  = 32'd524287;
    vecs[4].expd[3] = 32'd536869888;
    vecs[4].shift   = 4'd10;
    // Peak 2^29 (negative sample): at/above target, shift 0.
    for (int i = 0; i < N; i++) vecs[5].smp[i] = 32'd1;
    vecs[5].smp[0] = 32'hE000_0000;
    vecs[5].expd   = vecs[5].smp;
    vecs[5].shift  = 4'd0;
    // Peak 2^28-1: shift 1 fits, shift 2 does not.
    for (int i = 0; i < N; i++) begin
      vecs[6].smp[i]  = 32'hFFFF_FFFE;
      vecs[6].expd[i] = 32'hFFFF_FFFC;
    end
    vecs[6].smp[15]  = 32'd268435455;
    vecs[6].expd[15] = 32'd536870910;
    vecs[6].shift    = 4'd1;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst out_shift", 32'(out_shift), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    run_block(0, 1'b0, 1'b0, 32'd0);
    run_block(1, 1'b1, 1'b0, 32'd0);
    run_block(2, 1'b0, 1'b0, 32'd0);
    run_block(3, 1'b1, 1'b0, 32'd0);
    run_block(4, 1'b0, 1'b0, 32'd0);
    // Back-to-back: in_valid stays high across CALC/DRAIN.
    run_block(5, 1'b0, 1'b1, vecs[6].smp[0]);
    run_block(6, 1'b1, 1'b0, 32'd0);

    // Reset mid-FILL: the 7 large samples must be discarded.
    for (int i = 0; i < 7; i++) send(32'h0100_0000);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midfill rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midfill in_ready", 32'(in_ready), 32'd1);
    check("midfill out_valid", 32'(out_valid), 32'd0);
    run_block(3, 1'b0, 1'b0, 32'd0);

    // Reset mid-DRAIN after three output transfers.
    for (int i = 0; i < N; i++) send(vecs[0].smp[i]);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("middrain out_valid", 32'(out_valid), 32'd0);
    check("middrain out_shift", 32'(out_shift), 32'd0);
    check("middrain out_last", 32'(out_last), 32'd0);
    check("middrain in_ready", 32'(in_ready), 32'd1);
    run_block(4, 1'b1, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
